// File: rtl/mem_pkg.sv
// Shared types and default widths for the MAR/MDR memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_WAIT   = 2'd2,
        MEM_DONE   = 2'd3
    } mem_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op_t;

    localparam int DEF_ADDR_WIDTH  = 9;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_WAIT_STATES = 2;

endpackage

// File: rtl/mem_responder_if.sv
// Control-unit <-> memory responder bus; parity_err exists only when MEM_PARITY_EN is defined.
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  mem_ready;
    logic                  busy;
`ifdef MEM_PARITY_EN
    logic                  parity_err;

    modport master (output address, data_in, read, write,
                    input  data_out, mem_ready, busy, parity_err);
    modport slave  (input  address, data_in, read, write,
                    output data_out, mem_ready, busy, parity_err);
`else
    modport master (output address, data_in, read, write,
                    input  data_out, mem_ready, busy);
    modport slave  (input  address, data_in, read, write,
                    output data_out, mem_ready, busy);
`endif
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM, read-before-write, contents never cleared.
module mem_array #(
    parameter int ADDR_WIDTH = 9,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] din,
    output logic [WORD_WIDTH-1:0] dout
);
    logic [WORD_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        dout <= r_mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// Memory responder FSM: IDLE -> ACCESS -> WAIT x WAIT_STATES -> DONE, four-phase ready handshake.
// Optional even-parity protection of the array is enabled with `define MEM_PARITY_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input logic            clk,
    input logic            reset,
    mem_responder_if.slave bus
);
`ifdef MEM_PARITY_EN
    localparam int WORD_WIDTH = DATA_WIDTH + 1;
`else
    localparam int WORD_WIDTH = DATA_WIDTH;
`endif
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    mem_state_t            r_state, w_next;
    mem_op_t               r_op;
    logic [ADDR_WIDTH-1:0] r_addr, w_ram_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_data_out;
    logic [WORD_WIDTH-1:0] w_ram_din, w_ram_dout;
    logic [3:0]            r_cnt;
    logic                  w_req, w_accept, w_we;

    assign w_req    = bus.read | bus.write;
    assign w_accept = (r_state == MEM_IDLE) && w_req;
    assign w_we     = (r_state == MEM_ACCESS) && (r_op == OP_WR) && !reset;

    // The RAM reads the incoming address while idle so its registered output
    // already holds the requested word during the ACCESS cycle.
    assign w_ram_addr = (r_state == MEM_IDLE) ? bus.address : r_addr;

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .WORD_WIDTH(WORD_WIDTH)
    ) u_array (
        .clk (clk),
        .we  (w_we),
        .addr(w_ram_addr),
        .din (w_ram_din),
        .dout(w_ram_dout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            MEM_IDLE:   if (w_req) w_next = MEM_ACCESS;
            MEM_ACCESS: w_next = (WAIT_STATES > 0) ? MEM_WAIT : MEM_DONE;
            MEM_WAIT:   if (r_cnt == 4'd0) w_next = MEM_DONE;
            MEM_DONE:   if (!w_req) w_next = MEM_IDLE;
            default:    w_next = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= MEM_IDLE;
            r_cnt      <= 4'd0;
            r_data_out <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == MEM_ACCESS) begin
                r_cnt <= CNT_LOAD;
            end else if ((r_state == MEM_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if ((r_state == MEM_ACCESS) && (r_op == OP_RD)) begin
                r_data_out <= w_ram_dout[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= bus.write ? OP_WR : OP_RD;
            r_addr  <= bus.address;
            r_wdata <= bus.data_in;
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.mem_ready = (r_state == MEM_DONE);
    assign bus.busy      = (r_state != MEM_IDLE);

`ifdef MEM_PARITY_EN
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    logic r_par_bad, r_parity_err, w_par_hit;

    assign w_ram_din = {even_parity(r_wdata), r_wdata};
    // Stored bit XOR data bits is zero for an intact word.
    assign w_par_hit = (r_state == MEM_ACCESS) ? ((r_op == OP_RD) && (^w_ram_dout)) : r_par_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == MEM_ACCESS) begin
                r_par_bad <= w_par_hit;
            end
            if (w_accept) begin
                r_parity_err <= 1'b0;
            end else if ((w_next == MEM_DONE) && (r_state != MEM_DONE) && w_par_hit) begin
                r_parity_err <= 1'b1;
            end
        end
    end

    assign bus.parity_err = r_parity_err;
`else
    assign w_ram_din = r_wdata;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench: two responders (WAIT_STATES=2 and 0) against an array model.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [31:0] m2 [512];
    logic [31:0] m0 [512];
    logic [31:0] m_dout2 = 32'h0;
    logic [31:0] m_dout0 = 32'h0;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) b2 ();
    mem_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) b0 ();

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(2)) u2 (
        .clk(clk), .reset(rst), .bus(b2));
    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset(rst), .bus(b0));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [8:0] a, input logic [31:0] d);
        if (sel == 0) begin
            b0.read = rd; b0.write = wr; b0.address = a; b0.data_in = d;
        end else begin
            b2.read = rd; b2.write = wr; b2.address = a; b2.data_in = d;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? b0.mem_ready : b2.mem_ready;
    endfunction
    function automatic logic bsy(input int sel);
        return (sel == 0) ? b0.busy : b2.busy;
    endfunction
    function automatic logic [31:0] dout_of(input int sel);
        return (sel == 0) ? b0.data_out : b2.data_out;
    endfunction

    // lat = rising edges from raising the strobe until mem_ready is seen:
    // one to accept, one for ACCESS, then one per wait state.
    task automatic xfer(input int sel, input bit rd, input bit wr, input logic [8:0] a,
                        input logic [31:0] d, input bit chg, input bit drop, input int hold,
                        output int lat, output logic [31:0] dout);
        drive(sel, rd, wr, a, d);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1 && chg) drive(sel, rd, wr, a + 9'd1, ~d);
            if (lat == 1 && drop) drive(sel, 1'b0, 1'b0, a, d);
            if (rdy(sel)) break;
        end
        if (lat >= 40) check("ready_timeout", 32'(rdy(sel)), 32'd1);
        dout = dout_of(sel);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("ready_held", 32'(rdy(sel)), 32'd1);
            check("busy_held", 32'(bsy(sel)), 32'd1);
        end
        drive(sel, 1'b0, 1'b0, a, d);
        @(posedge clk); #1;
        check("ready_drop", 32'(rdy(sel)), 32'd0);
        check("busy_drop", 32'(bsy(sel)), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] dout;
        drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 9'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy2", 32'(b2.busy), 32'd0);
        check("rst_ready2", 32'(b2.mem_ready), 32'd0);
        check("rst_dout2", b2.data_out, 32'h0);
        check("rst_busy0", 32'(b0.busy), 32'd0);
        check("rst_ready0", 32'(b0.mem_ready), 32'd0);
        check("rst_dout0", b0.data_out, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Write then read, two wait states
        xfer(2, 0, 1, 9'h05, 32'hDEADBEEF, 0, 0, 0, lat, dout);
        m2[9'h05] = 32'hDEADBEEF;
        check("wr05_lat", lat, 4);
        check("wr05_dout", dout, m_dout2);
        xfer(2, 1, 0, 9'h05, 32'h0, 0, 0, 0, lat, dout);
        m_dout2 = m2[9'h05];
        check("rd05_lat", lat, 4);
        check("rd05_dout", dout, m_dout2);

        // Zero wait states, read held three extra cycles
        xfer(0, 0, 1, 9'h1FF, 32'h12345678, 0, 0, 0, lat, dout);
        m0[9'h1FF] = 32'h12345678;
        check("wr1ff_lat", lat, 2);
        xfer(0, 1, 0, 9'h1FF, 32'h0, 0, 0, 3, lat, dout);
        m_dout0 = m0[9'h1FF];
        check("rd1ff_lat", lat, 2);
        check("rd1ff_dout", dout, m_dout0);

        // Both strobes high is a write
        xfer(2, 1, 1, 9'h10, 32'hA5A5A5A5, 0, 0, 0, lat, dout);
        m2[9'h10] = 32'hA5A5A5A5;
        check("both_dout", dout, m_dout2);
        xfer(2, 1, 0, 9'h10, 32'h0, 0, 0, 0, lat, dout);
        m_dout2 = m2[9'h10];
        check("rd10_dout", dout, m_dout2);

        // Address/data changed after acceptance are ignored
        xfer(2, 0, 1, 9'h21, 32'h33333333, 0, 0, 0, lat, dout);
        m2[9'h21] = 32'h33333333;
        xfer(2, 0, 1, 9'h20, 32'h11111111, 1, 0, 0, lat, dout);
        m2[9'h20] = 32'h11111111;
        xfer(2, 1, 0, 9'h20, 32'h0, 0, 0, 0, lat, dout);
        m_dout2 = m2[9'h20];
        check("rd20_dout", dout, m_dout2);
        xfer(2, 1, 0, 9'h21, 32'h0, 0, 0, 0, lat, dout);
        m_dout2 = m2[9'h21];
        check("rd21_dout", dout, m_dout2);

        // Reset during the ACCESS cycle of a write suppresses it
        xfer(2, 0, 1, 9'h30, 32'h0, 0, 0, 0, lat, dout);
        m2[9'h30] = 32'h0;
        drive(2, 1'b0, 1'b1, 9'h30, 32'hFFFFFFFF);
        @(posedge clk); #1;
        check("acc_busy", 32'(b2.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_dout2 = 32'h0;
        m_dout0 = 32'h0;
        check("rstacc_busy", 32'(b2.busy), 32'd0);
        check("rstacc_ready", 32'(b2.mem_ready), 32'd0);
        check("rstacc_dout", b2.data_out, m_dout2);
        drive(2, 1'b0, 1'b0, 9'h30, 32'h0);
        @(posedge clk); #1;
        xfer(2, 1, 0, 9'h30, 32'h0, 0, 0, 0, lat, dout);
        m_dout2 = m2[9'h30];
        check("rd30_dout", dout, m_dout2);

        // Randomized traffic over a preloaded window
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            d = $urandom;
            xfer(2, 0, 1, 9'h60 + 9'(i), d, 0, 0, 0, lat, dout);
            m2[9'h60 + 9'(i)] = d;
        end
        for (int i = 0; i < 40; i++) begin
            int          op;
            int          sel;
            int          hold;
            bit          chg;
            bit          drop;
            logic [8:0]  a;
            logic [31:0] d;
            op   = int'($urandom_range(0, 2));
            sel  = ($urandom_range(0, 1) == 0) ? 0 : 2;
            a    = 9'h60 + 9'($urandom_range(0, 15));
            d    = $urandom;
            chg  = ($urandom_range(0, 3) == 0);
            drop = ($urandom_range(0, 3) == 0);
            hold = drop ? 0 : int'($urandom_range(0, 2));
            if (sel == 0 && i == 0) begin
                for (int j = 0; j < 16; j++) begin
                    xfer(0, 0, 1, 9'h60 + 9'(j), m2[9'h60 + 9'(j)], 0, 0, 0, lat, dout);
                    m0[9'h60 + 9'(j)] = m2[9'h60 + 9'(j)];
                end
            end else if (sel == 0 && m0[9'h60] !== m2[9'h60] && m0[9'h60] === 32'hx) begin
                sel = 2;
            end
            xfer(sel, op != 1, op != 0, a, d, chg, drop, hold, lat, dout);
            check("rnd_lat", lat, (sel == 0) ? 2 : 4);
            if (sel == 0) begin
                if (op == 0) m_dout0 = m0[a];
                else m0[a] = d;
                check("rnd_dout0", dout, m_dout0);
            end else begin
                if (op == 0) m_dout2 = m2[a];
                else m2[a] = d;
                check("rnd_dout2", dout, m_dout2);
            end
        end

`ifdef MEM_PARITY_EN
        xfer(2, 0, 1, 9'h40, 32'h0F0F0F01, 0, 0, 0, lat, dout);
        m2[9'h40] = 32'h0F0F0F01;
        xfer(2, 1, 0, 9'h40, 32'h0, 0, 0, 0, lat, dout);
        m_dout2 = m2[9'h40];
        check("par_clean", 32'(b2.parity_err), 32'd0);
        u2.u_array.r_mem[9'h40][32] = ~u2.u_array.r_mem[9'h40][32];
        drive(2, 1'b1, 1'b0, 9'h40, 32'h0);
        lat = 0;
        while (lat < 40 && !b2.mem_ready) begin
            @(posedge clk); #1;
            lat++;
        end
        check("par_err_set", 32'(b2.parity_err), 32'd1);
        check("par_dout", b2.data_out, m_dout2);
        drive(2, 1'b0, 1'b0, 9'h40, 32'h0);
        @(posedge clk); #1;
        xfer(2, 1, 0, 9'h05, 32'h0, 0, 0, 0, lat, dout);
        m_dout2 = m2[9'h05];
        check("par_err_clr", 32'(b2.parity_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
